// File: rtl/eq_pkg.sv
// Shared definitions for the equality-mask decoder: default word width and FSM states.
package eq_pkg;

    localparam int DEFAULT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : eq_pkg

// File: rtl/eq_bit_decode.sv
// One-bit decode: recovers y from known x and equality flag e (y = x when equal, else ~x).
module eq_bit_decode (
    input  logic x,
    input  logic e,
    output logic y
);

    assign y = ~(x ^ e);

endmodule : eq_bit_decode

// File: rtl/eq_mask_decoder.sv
// Serial reconstruction of operand y from a known operand x and a per-bit equality mask.
module eq_mask_decoder
    import eq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ref_word,
    input  logic [WIDTH-1:0] eq_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             all_equal,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] x_sr;
    logic [WIDTH-1:0] m_sr;
    logic             accept;
    logic             shift_en;
    logic             bit_y;
    logic             in_ready_nxt;
    logic             out_valid_nxt;
    logic             busy_nxt;

    eq_bit_decode u_bit_decode (
        .x (x_sr[0]),
        .e (m_sr[0]),
        .y (bit_y)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        shift_en  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // The counter reaches WIDTH one cycle after the last bit, which
                // gives the WIDTH+1 accept-to-valid latency.
                if (cnt == LAST_CNT) begin
                    state_nxt = DONE;
                end else begin
                    shift_en = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        in_ready_nxt  = (state_nxt == IDLE);
        out_valid_nxt = (state_nxt == DONE);
        busy_nxt      = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            busy      <= busy_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            x_sr      <= '0;
            m_sr      <= '0;
            out_word  <= '0;
            all_equal <= 1'b0;
        end else if (accept) begin
            cnt       <= '0;
            x_sr      <= ref_word;
            m_sr      <= eq_mask;
            all_equal <= 1'b1;
        end else if (shift_en) begin
            // Decoded bits enter at the MSB; after WIDTH shifts bit i sits at position i.
            cnt       <= cnt + 1'b1;
            x_sr      <= x_sr >> 1;
            m_sr      <= m_sr >> 1;
            out_word  <= {bit_y, out_word[WIDTH-1:1]};
            all_equal <= all_equal & m_sr[0];
        end
    end

endmodule : eq_mask_decoder

// File: tb/tb_eq_mask_decoder.sv
// Self-checking bench for eq_mask_decoder: directed vectors plus randomized pairs against a bit-rule model.
module tb_eq_mask_decoder;

    localparam int W = 5;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] ref_word;
    logic [W-1:0] eq_mask;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_word;
    logic         all_equal;
    logic         busy;

    int n_cmp;
    int n_bad;

    eq_mask_decoder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ref_word  (ref_word),
        .eq_mask   (eq_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .all_equal (all_equal),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: where the mask says equal, y copies x; elsewhere y is the inverse of x.
    function automatic logic [W-1:0] model_word(input logic [W-1:0] x, input logic [W-1:0] m);
        logic [W-1:0] y;
        for (int i = 0; i < W; i++) begin
            if (m[i]) y[i] = x[i];
            else      y[i] = !x[i];
        end
        return y;
    endfunction

    function automatic logic model_all_eq(input logic [W-1:0] m);
        int ones;
        ones = 0;
        for (int i = 0; i < W; i++) ones += int'(m[i]);
        return (ones == W);
    endfunction

    // Offers a pair (called #1 after an edge) and returns once it has been accepted.
    task automatic accept_pair(input logic [W-1:0] x, input logic [W-1:0] m, output bit ok);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        ref_word = x;
        eq_mask  = m;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        ok = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ref_word = W'($urandom);
        eq_mask  = W'($urandom);
    endtask

    // Counts edges from the accepting edge until out_valid is seen; -1 on timeout.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 20);
        if (!out_valid) lat = -1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ref_word  = '0;
        eq_mask   = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, busy, all_equal, out_word} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b eq=%b word=%b, need all 0",
                     in_ready, out_valid, busy, all_equal, out_word);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b, need 1", in_ready);
        end
    endtask

    task automatic check_txn(input string name, input logic [W-1:0] x, input logic [W-1:0] m,
                             input int lat);
        n_cmp++;
        if (lat != W + 1) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d, need %0d", name, lat, W + 1);
        end
        n_cmp++;
        if (out_word !== model_word(x, m)) begin
            n_bad++;
            $display("FAIL %s_word: got %b, need %b", name, out_word, model_word(x, m));
        end
        n_cmp++;
        if (all_equal !== model_all_eq(m)) begin
            n_bad++;
            $display("FAIL %s_all_equal: got %b, need %b", name, all_equal, model_all_eq(m));
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] xs [3];
        logic [W-1:0] ms [3];
        bit ok;
        int lat;
        xs = '{5'b10101, 5'b10011, 5'b10101};
        ms = '{5'b11111, 5'b11110, 5'b00000};
        for (int k = 0; k < 3; k++) begin
            accept_pair(xs[k], ms[k], ok);
            wait_result(lat);
            check_txn($sformatf("directed%0d", k), xs[k], ms[k], lat);
            n_cmp++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL directed%0d_done_flags: got busy=%b rdy=%b, need 1/0", k, busy, in_ready);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] x, m, exp_w;
        logic exp_e;
        bit ok;
        int lat;
        x = 5'b01101; m = 5'b10110;
        exp_w = model_word(x, m);
        exp_e = model_all_eq(m);
        accept_pair(x, m, ok);
        wait_result(lat);
        check_txn("bp", x, m, lat);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_word !== exp_w || all_equal !== exp_e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold%0d: got word=%b eq=%b vld=%b rdy=%b, need %b/%b/1/0",
                         k, out_word, all_equal, out_valid, in_ready, exp_w, exp_e);
            end
        end
        handshake();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_after_handshake: got vld=%b rdy=%b busy=%b, need 0/1/0",
                     out_valid, in_ready, busy);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_word !== exp_w) begin
            n_bad++;
            $display("FAIL bp_idle_hold: got %b, need %b", out_word, exp_w);
        end
    endtask

    task automatic test_ignore_in_valid();
        logic [W-1:0] x, m;
        bit ok;
        int lat;
        x = 5'b00110; m = 5'b01011;
        accept_pair(x, m, ok);
        // Offer a second pair mid-shift; it must have no effect.
        @(posedge clk); #1;
        in_valid = 1'b1; ref_word = 5'b11111; eq_mask = 5'b11111;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 2;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        check_txn("ignore", x, m, lat);
        handshake();
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] x, m;
        bit ok;
        int lat;
        accept_pair(5'b11001, 5'b00111, ok);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, busy, all_equal, out_word} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got rdy=%b vld=%b busy=%b eq=%b word=%b, need all 0",
                     in_ready, out_valid, busy, all_equal, out_word);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_ready: got %b, need 1", in_ready);
        end
        x = 5'b01110; m = 5'b11010;
        accept_pair(x, m, ok);
        wait_result(lat);
        check_txn("midreset_new", x, m, lat);
        handshake();
    endtask

    task automatic test_random();
        logic [W-1:0] x, m;
        bit ok;
        int lat;
        for (int k = 0; k < 25; k++) begin
            x = W'($urandom);
            m = W'($urandom);
            if (k % 5 == 0) m = '1;
            // Asserting out_ready early must not disturb SHIFT.
            out_ready = ($urandom_range(0, 1) == 1);
            accept_pair(x, m, ok);
            wait_result(lat);
            check_txn($sformatf("rand%0d", k), x, m, lat);
            if (out_ready) begin
                @(posedge clk); #1;
                out_ready = 1'b0;
            end else begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #0;
                handshake();
            end
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL rand%0d_release: got vld=%b rdy=%b, need 0/1", k, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_ignore_in_valid();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_eq_mask_decoder

// File: doc/eq_mask_decoder.md
EQ_MASK_DECODER -- requirements
Module: eq_mask_decoder

Interface
REQ-001 Parameter WIDTH, default 5, sets the word width of ref_word, eq_mask and out_word.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  ref_word/eq_mask pair offered.
REQ-005 in_ready  output  1  block can accept a pair this cycle.
REQ-006 ref_word  input  WIDTH  known operand x.
REQ-007 eq_mask  input  WIDTH  per-bit equality vector, bit i = 1 when x[i] == y[i].
REQ-008 out_valid  output  1  reconstructed word available.
REQ-009 out_ready  input  1  downstream accepts out_word.
REQ-010 out_word  output  WIDTH  reconstructed operand y.
REQ-011 all_equal  output  1  1 when every eq_mask bit was 1.
REQ-012 busy  output  1  high in SHIFT or DONE.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE; out_valid, in_ready and busy are registered outputs.
REQ-014 IDLE: in_ready=1; the pair SHALL be captured into shift registers when in_valid&in_ready, with a transition to SHIFT and bit counter cleared to 0.
REQ-015 SHIFT: one bit per clock, LSB first; y[i] = NOT(x[i] XOR eq_mask[i]), shifted into out_word at position i.
REQ-016 SHIFT: all_equal accumulates as the AND of processed mask bits; it is preset to 1 at capture.
REQ-017 The counter is ceil(log2(WIDTH+1)) bits; after bit WIDTH-1 is processed the FSM SHALL enter DONE, with no wrap.
REQ-018 Latency: out_valid SHALL rise exactly WIDTH+1 clocks after the accepting edge (6 for WIDTH=5).
REQ-019 DONE: out_valid=1; out_word and all_equal SHALL hold stable until out_valid&out_ready.
REQ-020 On handshake in DONE: out_valid cleared, FSM to IDLE, in_ready=1 on the following cycle; no same-cycle reaccept.
REQ-021 in_valid outside IDLE SHALL be ignored; inputs are sampled only at the accepting edge.
REQ-022 out_ready outside DONE SHALL have no effect.
REQ-023 out_word SHALL hold the last completed result in IDLE until the next capture overwrites it.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, counter 0, out_word 0, all_equal 0, out_valid 0, busy 0, in_ready 0.
REQ-025 in_ready SHALL go to 1 on the first rising clk edge after rst_n deasserts.
REQ-026 Reset during SHIFT or DONE SHALL discard the transaction with no partial output.

Structure
REQ-027 Shared package eq_pkg SHALL hold the default WIDTH constant and the state enumeration (IDLE, SHIFT, DONE).
REQ-028 A single sub-module eq_bit_decode (one-bit XNOR decode: y = NOT(x XOR e)) SHALL be instantiated once for the serial bit path.
REQ-029 No other hierarchy is required.

Verification
REQ-030 ref 10101, mask 11111 -> out_word 10101, all_equal 1, out_valid 6 cycles after accept.
REQ-031 ref 10011, mask 11110 -> out_word 10010, all_equal 0.
REQ-032 ref 10101, mask 00000 -> out_word 01010, all_equal 0.
REQ-033 out_ready held low 3 cycles in DONE -> out_word/all_equal stable, in_ready 0; IDLE one cycle after handshake.
REQ-034 in_valid pulsed with ref 11111 during SHIFT -> ignored; the result reflects only the first pair.
REQ-035 rst_n low at counter=2 -> all outputs 0 at once; after release in_ready=1 next edge; a new pair decodes correctly.
